// File: rtl/rom_scan_reader.sv
// Purpose: walks every ROM address in order and re-presents each returned word with its address; optional XOR checksum (ROM_SCAN_CHECKSUM_EN).
// Latency: start sampled at E0 -> ISSUE cycle 1, WAIT cycle 2, out_valid from cycle 3; 3 cycles per word with out_ready high.
// Backpressure: out_ready low holds HOLD (data/addr stable) indefinitely; start is ignored outside IDLE.
module rom_scan_reader #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    state_t            state;
    logic [ADDR_W-1:0] cnt;

    // Scan sequencer: every output is a register updated alongside the state transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            rom_addr  <= '0;
            rom_en    <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            // rom_en and done are single-cycle strobes unless a branch raises them
            rom_en <= 1'b0;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_ISSUE;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        rom_en   <= 1'b1;
                        rom_addr <= '0;
                    end
                end
                S_ISSUE: begin
                    // ROM registers its word on this cycle's closing edge
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    out_data  <= rom_data;
                    out_addr  <= cnt;
                    out_valid <= 1'b1;
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (cnt == CNT_LAST) begin
                            // all-ones address ends the scan; cnt never wraps
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            cnt      <= cnt + 1'b1;
                            rom_addr <= cnt + 1'b1;
                            rom_en   <= 1'b1;
                            state    <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    // start seen here is dropped: no queuing of a restart
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ROM_SCAN_CHECKSUM_EN
    // Running XOR of accepted words; cleared as a scan starts, held after done until the next start.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= '0;
        end else if (state == S_IDLE && start) begin
            checksum <= '0;
        end else if (state == S_HOLD && out_ready) begin
            checksum <= checksum ^ out_data;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_rom_scan_reader.sv
module tb_rom_scan_reader;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 4;
    localparam int NW     = 1 << ADDR_W;
    localparam int LOGN   = 64;

`ifdef ROM_SCAN_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              out_ready = 1'b0;
    logic              busy;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_valid;
    logic              done;
    logic [DATA_W-1:0] checksum;

    rom_scan_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
        .out_ready(out_ready), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Behavioural ROM contents 0:1, 1:2, 2:4, 3:8 with one-cycle registered read
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] one;
        one = 1;
        return one << a;
    endfunction

    always @(posedge clk) if (rom_en) rom_data <= rom_word(rom_addr);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    int edge_cnt = 0;
    int base = 0;
    bit rst_s = 1'b1;
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        rst_s    <= reset;
    end

    // Per-cycle logs, indexed by cycle number relative to the start-sampling edge
    bit                lg_busy [0:LOGN-1];
    bit                lg_en   [0:LOGN-1];
    bit                lg_hs   [0:LOGN-1];
    bit                lg_done [0:LOGN-1];
    bit                lg_vld  [0:LOGN-1];
    logic [DATA_W-1:0] lg_data [0:LOGN-1];
    logic [ADDR_W-1:0] lg_addr [0:LOGN-1];
    logic [DATA_W-1:0] lg_chk  [0:LOGN-1];

    // Model state: next address the scan must produce, running XOR, pending done, stall snapshot
    int                exp_addr = 0;
    logic [DATA_W-1:0] exp_sum = '0;
    bit                done_due = 1'b0;
    bit                stalled = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [ADDR_W-1:0] prev_addr;

    // Compare process: checks the DUT against the scan model every cycle
    always @(negedge clk) begin
        int cyc;
        bit hs;
        cyc = edge_cnt - base + 1;
        if (cyc >= 0 && cyc < LOGN) begin
            lg_busy[cyc] = busy;
            lg_en[cyc]   = rom_en;
            lg_done[cyc] = done;
            lg_vld[cyc]  = out_valid;
            lg_data[cyc] = out_data;
            lg_addr[cyc] = out_addr;
            lg_chk[cyc]  = checksum;
            lg_hs[cyc]   = 1'b0;
        end
        if (rst_s) begin
            check("reset_outputs",
                  {busy, rom_en, rom_addr, out_valid, out_addr, out_data, done, checksum}, 32'd0);
            exp_addr = 0;
            exp_sum  = '0;
            done_due = 1'b0;
            stalled  = 1'b0;
        end else begin
            check("done_pulse", done, done_due);
            if (done_due && CK_EN) check("checksum_at_done", checksum, exp_sum);
            if (!CK_EN) check("checksum_tied_zero", checksum, 32'd0);
            done_due = 1'b0;
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_word", {out_addr, out_data}, {prev_addr, prev_data});
            end
            if (rom_en) check("rom_addr_order", rom_addr, exp_addr);
            stalled = 1'b0;
            if (out_valid) begin
                check("out_addr", out_addr, exp_addr);
                check("out_data", out_data, rom_word(exp_addr[ADDR_W-1:0]));
                hs = out_ready && !reset;
                if (hs) begin
                    if (cyc >= 0 && cyc < LOGN) lg_hs[cyc] = 1'b1;
                    exp_sum = (exp_addr == 0) ? rom_word(0) : (exp_sum ^ rom_word(exp_addr[ADDR_W-1:0]));
                    if (exp_addr == NW - 1) begin
                        done_due = 1'b1;
                        exp_addr = 0;
                    end else begin
                        exp_addr++;
                    end
                end else if (!out_ready) begin
                    stalled   = 1'b1;
                    prev_data = out_data;
                    prev_addr = out_addr;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulses start in cycle 0, then drives each cycle; ready low in [rdy_a,rdy_b]
    task automatic run(input int ncyc, input int rdy_a, input int rdy_b,
                       input bit start_held, input int start_extra, input int rst_cyc);
        for (int i = 0; i < LOGN; i++) begin
            lg_busy[i] = 1'b0; lg_en[i] = 1'b0; lg_hs[i] = 1'b0;
            lg_done[i] = 1'b0; lg_vld[i] = 1'b0;
        end
        base      = edge_cnt + 1;
        start     = 1'b1;
        out_ready = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            step(1);
            start     = start_held || (c == start_extra);
            out_ready = !(c >= rdy_a && c <= rdy_b);
            reset     = (c == rst_cyc);
        end
        step(1);
        start     = 1'b0;
        reset     = 1'b0;
        out_ready = 1'b1;
        step(3);
    endtask

    // Every cycle in [lo,hi] must show the event exactly at the listed cycles
    task automatic expect_events(input string name, input bit lg[0:LOGN-1],
                                 input int lo, input int hi, input int e[8]);
        for (int c = lo; c <= hi; c++) begin
            bit want;
            want = 1'b0;
            for (int k = 0; k < 8; k++) if (e[k] == c) want = 1'b1;
            check(name, lg[c], want);
        end
    endtask

    initial begin
        // Reset for two cycles, then idle
        step(2);
        reset = 1'b0;
        step(2);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
        check("idle_done", done, 0);
        check("idle_rom_en", rom_en, 0);
        @(posedge clk);
        #1;

        // Plain scan, ready tied high
        run(16, -1, -1, 1'b0, -1, -1);
        expect_events("hs_plain", lg_hs, 1, 16, '{3, 6, 9, 12, -1, -1, -1, -1});
        expect_events("done_plain", lg_done, 1, 16, '{13, -1, -1, -1, -1, -1, -1, -1});
        check("word0", {lg_addr[3], lg_data[3]}, {2'd0, 4'h1});
        check("word1", {lg_addr[6], lg_data[6]}, {2'd1, 4'h2});
        check("word2", {lg_addr[9], lg_data[9]}, {2'd2, 4'h4});
        check("word3", {lg_addr[12], lg_data[12]}, {2'd3, 4'h8});
        check("checksum_final", lg_chk[13], CK_EN ? 4'hF : 4'h0);
        check("checksum_held", lg_chk[16], CK_EN ? 4'hF : 4'h0);
        check("busy_c1", lg_busy[1], 1);
        check("busy_c13", lg_busy[13], 1);
        check("busy_c14", lg_busy[14], 0);
        check("valid_c2", lg_vld[2], 0);
        check("valid_c3", lg_vld[3], 1);

        // Ready low for 5 cycles while address 1 is held
        run(20, 6, 10, 1'b0, -1, -1);
        for (int c = 6; c <= 10; c++) begin
            check("stall_lit_data", lg_data[c], 4'h2);
            check("stall_lit_addr", lg_addr[c], 2'd1);
        end
        expect_events("hs_stall", lg_hs, 1, 20, '{3, 11, 14, 17, -1, -1, -1, -1});
        expect_events("done_stall", lg_done, 1, 20, '{18, -1, -1, -1, -1, -1, -1, -1});

        // Start held high: back-to-back scans
        run(27, -1, -1, 1'b1, -1, -1);
        expect_events("hs_b2b", lg_hs, 1, 30, '{3, 6, 9, 12, 17, 20, 23, 26});
        expect_events("done_b2b", lg_done, 1, 30, '{13, 27, -1, -1, -1, -1, -1, -1});
        expect_events("issue_b2b", lg_en, 1, 30, '{1, 4, 7, 10, 15, 18, 21, 24});
        check("busy_b2b_c14", lg_busy[14], 0);
        check("busy_b2b_c15", lg_busy[15], 1);

        // Reset while holding address 2
        run(20, -1, -1, 1'b0, -1, 9);
        check("rst_hold_valid_c9", lg_vld[9], 1);
        check("rst_hold_addr_c9", lg_addr[9], 2'd2);
        check("rst_busy_c10", lg_busy[10], 0);
        check("rst_valid_c10", lg_vld[10], 0);
        expect_events("hs_rst", lg_hs, 1, 20, '{3, 6, -1, -1, -1, -1, -1, -1});
        expect_events("done_rst", lg_done, 1, 20, '{-1, -1, -1, -1, -1, -1, -1, -1});

        // Rescan after the abort starts from address 0; start in DONE is ignored
        run(20, -1, -1, 1'b0, 13, -1);
        check("rescan_word0", {lg_addr[3], lg_data[3]}, {2'd0, 4'h1});
        check("rescan_checksum", lg_chk[13], CK_EN ? 4'hF : 4'h0);
        expect_events("done_ignore", lg_done, 1, 20, '{13, -1, -1, -1, -1, -1, -1, -1});
        expect_events("issue_ignore", lg_en, 1, 20, '{1, 4, 7, 10, -1, -1, -1, -1});
        check("ignore_busy_c14", lg_busy[14], 0);
        check("ignore_busy_c15", lg_busy[15], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
